// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and packing helpers for the write-back path of the 3R/1W register file.
// Reused by issue and write-back stages so packed requester buses agree everywhere.
package regfile_wb_arbiter_pkg;

  localparam int N_REQ_DEF      = 3;
  localparam int N_ELEMENTS_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 3;
  localparam int DATA_WIDTH_DEF = 16;

  // Low bit of requester idx's field inside a packed per-requester bus.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Generic N-way round-robin arbiter: one-hot grant scanning from the pointer,
// pointer moves just past the winner whenever a grant is given.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  input  logic         i_en,
  output logic [N-1:0] o_grant
);

  logic [PW-1:0] r_ptr;
  logic [N-1:0]  w_grant;
  logic [PW-1:0] w_gidx;
  logic          w_found;
  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;

  // A grant only ever goes to a valid requester, so any grant is also a handshake.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(N)) w_sum = w_sum - (PW+1)'(N);
      w_idx = w_sum[PW-1:0];
      if (!w_found && i_en && i_req[w_idx]) begin
        w_found        = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_gidx         = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_gidx == PW'(N-1)) ? '0 : w_gidx + PW'(1);
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file write port: round-robin grant, registered
// write channel, and a per-register busy scoreboard with a WAW reservation flag.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N_ELEMENTS = N_ELEMENTS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N_REQ      = N_REQ_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        wb_stall,
  input  logic                        rsv_en,
  input  logic [ADDR_WIDTH-1:0]       rsv_addr,
  output logic [ADDR_WIDTH-1:0]       w_addr,
  output logic [DATA_WIDTH-1:0]       w_data,
  output logic                        w_en,
  output logic [N_ELEMENTS-1:0]       busy,
  output logic                        rsv_conflict
);

  logic [N_REQ-1:0]      w_grant;
  logic                  w_hs;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [N_ELEMENTS-1:0] w_busy_nxt;
  logic                  w_rsv_hit;

  logic [ADDR_WIDTH-1:0] r_w_addr;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic                  r_w_en;
  logic [N_ELEMENTS-1:0] r_busy;
  logic                  r_rsv_conflict;

  // Gating by rst keeps ready low during reset, which drops any reset-cycle handshake.
  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .i_req   (req_valid),
    .i_en    (!rst && !wb_stall),
    .o_grant (w_grant)
  );

  always_comb begin
    w_hs       = |w_grant;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = req_addr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];
        w_sel_data = req_data[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  // Reserve beats commit on the same register: the new producer is still outstanding.
  always_comb begin
    w_busy_nxt = r_busy;
    w_rsv_hit  = 1'b0;
    for (int r = 0; r < N_ELEMENTS; r++) begin
      if (rsv_en && rsv_addr == ADDR_WIDTH'(r)) begin
        w_busy_nxt[r] = 1'b1;
        if (r_busy[r]) w_rsv_hit = 1'b1;
      end else if (r_w_en && r_w_addr == ADDR_WIDTH'(r)) begin
        w_busy_nxt[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_w_en         <= 1'b0;
      r_w_addr       <= '0;
      r_w_data       <= '0;
      r_busy         <= '0;
      r_rsv_conflict <= 1'b0;
    end else begin
      r_w_en         <= w_hs;
      r_busy         <= w_busy_nxt;
      r_rsv_conflict <= w_rsv_hit;
      if (w_hs) begin
        r_w_addr <= w_sel_addr;
        r_w_data <= w_sel_data;
      end
    end
  end

  assign req_ready    = w_grant;
  assign w_addr       = r_w_addr;
  assign w_data       = r_w_data;
  assign w_en         = r_w_en;
  assign busy         = r_busy;
  assign rsv_conflict = r_rsv_conflict;

endmodule
